regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised CPU register file, successor to the fixed 16x32 file. Three async read ports (s/t/d), one
//  sync write port with lane modes (full / upper half / lower half / link-reg), optional write-to-read
//  bypass, optional hardwired-zero r0 and a handshaked background clear engine. Sits in decode/writeback.
// PARAMETERS
//  DATA_W   32  register width; must be even (half-lane writes)
//  DEPTH    16  number of registers
//  ADDR_W   5   address width; addresses >= DEPTH are out of range
//  LINK_REG 11  target of WM_LINK writes
//  HALF_REG 10  target of WM_HI/WM_LO writes
//  ZERO_R0  0   1: r0 reads 0, writes to r0 dropped
//  BYPASS   1   1: read ports forward the value committing this cycle
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  addr_source  in   ADDR_W  read port S address
//  addr_temp    in   ADDR_W  read port T address
//  addr_dest    in   ADDR_W  read port D address
//  s_data_out   out  DATA_W  port S data (combinational)
//  t_data_out   out  DATA_W  port T data
//  d_data_out   out  DATA_W  port D data
//  we           in   1       write enable
//  wr_mode      in   2       00 FULL, 01 HI, 10 LO, 11 LINK
//  addr_wr_dest in   ADDR_W  write address (FULL mode only)
//  data_in      in   DATA_W  write data
//  wr_ready     out  1       1 = write accepted this cycle
//  clr_req      in   1       start background clear (level, sampled in IDLE)
//  clr_busy     out  1       clear in progress
//  clr_done     out  1       one-cycle pulse after last entry cleared
// BEHAVIOUR
//  - Reset: all DEPTH entries <= 0 in the reset cycle; FSM -> IDLE; clr_busy=0, clr_done=0, wr_ready=1.
//  - Commit: we && wr_ready at edge. FULL: rf[addr_wr_dest]<=data_in. HI: rf[HALF_REG][DATA_W-1:DATA_W/2]
//    <=data_in upper half, lower half kept. LO: lower half only. LINK: rf[LINK_REG]<=data_in.
//  - Dropped writes (no state change): FULL to addr>=DEPTH; FULL to r0 when ZERO_R0=1.
//  - Reads: rf[addr]; 0 when addr>=DEPTH or (ZERO_R0 && addr==0). Zero extra latency.
//  - BYPASS=1: if a write commits this cycle to the read address, port returns post-write value
//    (HI/LO merged with unchanged half). BYPASS=0: old value until next cycle. Reads during CLEAR
//    return stored contents (not yet cleared entries keep old data).
//  - Clear FSM (states IDLE, CLEAR, DONE):
//    IDLE: clr_req=1 -> CLEAR, idx<=0. CLEAR: rf[idx]<=0, idx++; idx==DEPTH-1 -> DONE.
//    DONE: clr_done=1 one cycle -> IDLE. clr_busy=1 in CLEAR and DONE. Clear takes DEPTH+1 cycles.
//  - wr_ready=0 in CLEAR and DONE; we in those cycles is ignored (caller must hold/retry).
//  - clr_req while busy: ignored. clr_req held high in DONE: new clear starts only after IDLE cycle.
//  - reset mid-clear: all entries 0, FSM IDLE next cycle, no clr_done pulse.
//  - we and clr_req same IDLE cycle: write commits, clear starts next cycle (write later cleared).
// STRUCTURE
//  - Package regfile_pkg: wr_mode encodings (WM_FULL/WM_HI/WM_LO/WM_LINK), clr_state enum.
//  - Sub-module regfile_clear_fsm: state, idx counter, clr_busy/clr_done/wr_ready, clear strobe+index.
//  - Top: storage array, write-lane merge, range/zero masking, per-port bypass mux.
// TESTING
//  1 Reset then FULL writes 0xDEAD_BEEF to r3, read S=3 same cycle -> BYPASS=1: 0xDEADBEEF; BYPASS=0: 0
//    then 0xDEADBEEF next cycle.
//  2 rf[10]=0x1111_2222; HI write 0xAAAA_0000 -> 0xAAAA2222; LO write 0x0000_BBBB -> 0xAAAABBBB.
//  3 LINK write 0x0000_0040 (addr_wr_dest=5) -> rf[11]=0x40, rf[5] unchanged.
//  4 Fill all 16 regs, pulse clr_req -> clr_busy 17 cycles, clr_done on cycle 17, all reads 0;
//    we during busy -> wr_ready=0, no change.
//  5 Assert reset at clear cycle 5 -> all reads 0 next cycle, clr_busy=0, no clr_done.
//  6 ZERO_R0=1: write 0x5 to r0 and to addr 20 -> reads of r0 and addr 20 return 0, others intact.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the parametrised register file: write lane modes and clear-engine states.
package regfile_pkg;

    typedef enum logic [1:0] {
        WM_FULL = 2'b00,
        WM_HI   = 2'b01,
        WM_LO   = 2'b10,
        WM_LINK = 2'b11
    } wr_mode_e;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'b00,
        CLR_CLEAR = 2'b01,
        CLR_DONE  = 2'b10
    } clr_state_e;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: three async read ports, one lane-mode write port and the clear handshake.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    import regfile_pkg::*;

    logic [ADDR_W-1:0] addr_source;
    logic [ADDR_W-1:0] addr_temp;
    logic [ADDR_W-1:0] addr_dest;
    logic [DATA_W-1:0] s_data_out;
    logic [DATA_W-1:0] t_data_out;
    logic [DATA_W-1:0] d_data_out;
    // Write handshake: we is the request, wr_ready the grant; a write commits on a rising
    // edge where both are high. A refused write is simply lost, so the caller holds we and
    // its payload until it sees wr_ready=1 at the edge.
    logic              we;
    wr_mode_e          wr_mode;
    logic [ADDR_W-1:0] addr_wr_dest;
    logic [DATA_W-1:0] data_in;
    logic              wr_ready;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output addr_source, addr_temp, addr_dest, we, wr_mode, addr_wr_dest, data_in, clr_req,
        input  s_data_out, t_data_out, d_data_out, wr_ready, clr_busy, clr_done
    );

    modport slave (
        input  addr_source, addr_temp, addr_dest, we, wr_mode, addr_wr_dest, data_in, clr_req,
        output s_data_out, t_data_out, d_data_out, wr_ready, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Background clear engine: walks every entry once, then pulses clr_done; blocks writes while busy.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_req,
    output clr_state_e       state,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_idx,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             wr_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLR_IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            wr_ready <= 1'b1;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state    <= CLR_CLEAR;
                        clr_idx  <= '0;
                        clr_busy <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                CLR_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state    <= CLR_DONE;
                        clr_done <= 1'b1;
                    end
                end
                CLR_DONE: begin
                    // Always pass through IDLE so a held clr_req restarts only after one open cycle.
                    state    <= CLR_IDLE;
                    clr_done <= 1'b0;
                    clr_busy <= 1'b0;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= CLR_IDLE;
                    clr_done <= 1'b0;
                    clr_busy <= 1'b0;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign clr_en = (state == CLR_CLEAR);

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: storage, write-lane merge, range/r0 masking and per-port bypass.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 11,
    parameter int HALF_REG = 10,
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1
) (
    input  logic       clk,
    input  logic       reset,
    regfile_if.slave   bus,
    output clr_state_e clr_state
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                HALF    = DATA_W / 2;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] HALF_A  = ADDR_W'(HALF_REG);
    localparam logic [ADDR_W-1:0] LINK_A  = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] rf [DEPTH];
    logic              clr_en;
    logic [IDX_W-1:0]  clr_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] half_cur;
    logic              wr_valid;

    regfile_clear_fsm #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_clear (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (bus.clr_req),
        .state    (clr_state),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx),
        .clr_busy (bus.clr_busy),
        .clr_done (bus.clr_done),
        .wr_ready (bus.wr_ready)
    );

    // An address is backed by storage unless it is past the end or is a hardwired r0.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    always_comb begin
        half_cur = rf[HALF_A[IDX_W-1:0]];
        wr_addr  = bus.addr_wr_dest;
        wr_val   = bus.data_in;
        case (bus.wr_mode)
            WM_HI: begin
                wr_addr = HALF_A;
                wr_val  = {bus.data_in[DATA_W-1:HALF], half_cur[HALF-1:0]};
            end
            WM_LO: begin
                wr_addr = HALF_A;
                wr_val  = {half_cur[DATA_W-1:HALF], bus.data_in[HALF-1:0]};
            end
            WM_LINK: wr_addr = LINK_A;
            default: ;
        endcase
    end

    assign wr_valid = bus.we && bus.wr_ready && addr_ok(wr_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (clr_en) begin
            rf[clr_idx] <= '0;
        end else if (wr_valid) begin
            rf[wr_addr[IDX_W-1:0]] <= wr_val;
        end
    end

    // Forwarding only covers the write port; clear-engine zeroing shows up one cycle later.
    assign bus.s_data_out = !addr_ok(bus.addr_source) ? '0 :
        ((BYPASS != 0) && wr_valid && (wr_addr == bus.addr_source)) ? wr_val :
        rf[bus.addr_source[IDX_W-1:0]];
    assign bus.t_data_out = !addr_ok(bus.addr_temp) ? '0 :
        ((BYPASS != 0) && wr_valid && (wr_addr == bus.addr_temp)) ? wr_val :
        rf[bus.addr_temp[IDX_W-1:0]];
    assign bus.d_data_out = !addr_ok(bus.addr_dest) ? '0 :
        ((BYPASS != 0) && wr_valid && (wr_addr == bus.addr_dest)) ? wr_val :
        rf[bus.addr_dest[IDX_W-1:0]];

endmodule

// File: tb/tb_regfile_param.sv
// Drives a bypass/no-r0 file and a no-bypass/zero-r0 file in lockstep against a behavioural model.
module tb_regfile_param;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic        clr_req;
    wr_mode_e    mode;
    logic [4:0]  wa;
    logic [31:0] din;
    logic [4:0]  rd_s, rd_t, rd_d;
    clr_state_e  st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    bit started = 1'b0;

    // Reference: committed contents per DUT, contents after this cycle's write, clear progress
    // (-1 idle, 0..15 entry being cleared, 16 done cycle).
    logic [31:0] mdl [2][16];
    logic [31:0] nxt [2][16];
    int          phase = -1;
    bit          zero_f [2] = '{1'b0, 1'b1};
    bit          byp_f  [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    regfile_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    regfile_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

    assign ifa.we = we;           assign ifb.we = we;
    assign ifa.wr_mode = mode;    assign ifb.wr_mode = mode;
    assign ifa.addr_wr_dest = wa; assign ifb.addr_wr_dest = wa;
    assign ifa.data_in = din;     assign ifb.data_in = din;
    assign ifa.clr_req = clr_req; assign ifb.clr_req = clr_req;
    assign ifa.addr_source = rd_s; assign ifb.addr_source = rd_s;
    assign ifa.addr_temp = rd_t;   assign ifb.addr_temp = rd_t;
    assign ifa.addr_dest = rd_d;   assign ifb.addr_dest = rd_d;

    regfile_param #(.ZERO_R0(0), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .clr_state(st_a)
    );
    regfile_param #(.ZERO_R0(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .clr_state(st_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_write();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) nxt[k][i] = mdl[k][i];
            if (!reset && we && phase < 0) begin
                case (mode)
                    WM_FULL: if (wa < 16 && !(zero_f[k] && wa == 0)) nxt[k][wa[3:0]] = din;
                    WM_HI:   nxt[k][10][31:16] = din[31:16];
                    WM_LO:   nxt[k][10][15:0] = din[15:0];
                    default: nxt[k][11] = din;
                endcase
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
        if (a >= 16) return 32'h0;
        if (zero_f[k] && a == 0) return 32'h0;
        return byp_f[k] ? nxt[k][a[3:0]] : mdl[k][a[3:0]];
    endfunction

    task automatic check_dut(input int k, input string nm, input logic [31:0] s,
                             input logic [31:0] t, input logic [31:0] d, input logic rdy,
                             input logic busy, input logic done);
        check_eq({nm, ".s"}, s, exp_rd(k, rd_s));
        check_eq({nm, ".t"}, t, exp_rd(k, rd_t));
        check_eq({nm, ".d"}, d, exp_rd(k, rd_d));
        check_eq({nm, ".wr_ready"}, 32'(rdy), 32'(phase < 0));
        check_eq({nm, ".clr_busy"}, 32'(busy), 32'(phase >= 0));
        check_eq({nm, ".clr_done"}, 32'(done), 32'(phase == 16));
    endtask

    // One clock: inputs are already set at the negedge; sample mid-low-phase, then advance model.
    task automatic tick();
        #2;
        model_write();
        if (started) begin
            check_dut(0, "a", ifa.s_data_out, ifa.t_data_out, ifa.d_data_out,
                      ifa.wr_ready, ifa.clr_busy, ifa.clr_done);
            check_dut(1, "b", ifb.s_data_out, ifb.t_data_out, ifb.d_data_out,
                      ifb.wr_ready, ifb.clr_busy, ifb.clr_done);
            check_eq("a.state", 32'(st_a),
                     (phase < 0) ? 32'(CLR_IDLE) : (phase < 16) ? 32'(CLR_CLEAR) : 32'(CLR_DONE));
        end
        if (ifa.clr_busy === 1'b1) busy_cnt++;
        if (ifa.clr_done === 1'b1) done_cnt++;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 16; i++) mdl[k][i] = 32'h0;
            phase = -1;
            started = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (phase >= 0 && phase < 16) nxt[k][phase] = 32'h0;
                for (int i = 0; i < 16; i++) mdl[k][i] = nxt[k][i];
            end
            if (phase < 0) phase = clr_req ? 0 : -1;
            else phase = (phase == 16) ? -1 : phase + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_wr(input logic w, input wr_mode_e m, input logic [4:0] a,
                            input logic [31:0] d);
        we = w; mode = m; wa = a; din = d;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            drive_wr(1'b1, WM_FULL, 5'(i), $urandom);
            rd_s = 5'($urandom_range(0, 19));
            tick();
        end
        drive_wr(1'b0, WM_FULL, 5'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; clr_req = 1'b0;
        drive_wr(1'b0, WM_FULL, 5'd0, 32'h0);
        rd_s = 5'd0; rd_t = 5'd1; rd_d = 5'd2;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Same-cycle read of a FULL write, then the settled value.
        drive_wr(1'b1, WM_FULL, 5'd3, 32'hDEAD_BEEF); rd_s = 5'd3;
        tick();
        drive_wr(1'b0, WM_FULL, 5'd0, 32'h0);
        tick();
        check_eq("t1_settled", ifb.s_data_out, 32'hDEAD_BEEF);

        // Half-lane merge into the half register.
        rd_s = 5'd10;
        drive_wr(1'b1, WM_FULL, 5'd10, 32'h1111_2222); tick();
        drive_wr(1'b1, WM_HI, 5'd0, 32'hAAAA_0000);    tick();
        drive_wr(1'b1, WM_LO, 5'd0, 32'h0000_BBBB);    tick();
        drive_wr(1'b0, WM_FULL, 5'd0, 32'h0);          tick();
        check_eq("t2_merge", ifa.s_data_out, 32'hAAAA_BBBB);

        // LINK ignores addr_wr_dest.
        rd_s = 5'd11; rd_t = 5'd5;
        drive_wr(1'b1, WM_LINK, 5'd5, 32'h0000_0040); tick();
        drive_wr(1'b0, WM_FULL, 5'd0, 32'h0);         tick();
        check_eq("t3_link", ifa.s_data_out, 32'h40);
        check_eq("t3_r5", ifa.t_data_out, 32'h0);

        // Full clear with writes attempted throughout.
        fill_all();
        busy_cnt = 0; done_cnt = 0;
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive_wr(1'b1, WM_FULL, 5'($urandom_range(0, 15)), $urandom);
            rd_s = 5'($urandom_range(0, 15)); rd_t = 5'($urandom_range(0, 15));
            rd_d = 5'($urandom_range(0, 15));
            tick();
        end
        check_eq("t4_busy_len", 32'(busy_cnt), 32'd17);
        check_eq("t4_done_cnt", 32'(done_cnt), 32'd1);

        // Reset on the fifth clear cycle.
        fill_all();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        done_cnt = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_s = 5'($urandom_range(0, 15));
            tick();
        end
        check_eq("t5_no_done", 32'(done_cnt), 32'd0);

        // Writes to r0 and an out-of-range address.
        rd_s = 5'd0; rd_t = 5'd20; rd_d = 5'd1;
        drive_wr(1'b1, WM_FULL, 5'd1, 32'h7);  tick();
        drive_wr(1'b1, WM_FULL, 5'd0, 32'h5);  tick();
        drive_wr(1'b1, WM_FULL, 5'd20, 32'h5); tick();
        drive_wr(1'b0, WM_FULL, 5'd0, 32'h0);  tick();
        check_eq("t6_r0_zero", ifb.s_data_out, 32'h0);
        check_eq("t6_oor", ifb.t_data_out, 32'h0);
        check_eq("t6_r1", ifb.d_data_out, 32'h7);

        // Random traffic including clears and occasional resets.
        for (int i = 0; i < 800; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            clr_req = ($urandom_range(0, 29) == 0);
            drive_wr(reset ? 1'b0 : 1'($urandom_range(0, 1)), wr_mode_e'($urandom_range(0, 3)),
                     5'($urandom_range(0, 19)), $urandom);
            rd_s = 5'($urandom_range(0, 19));
            rd_t = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 19));
            rd_d = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 19));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
